// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 hex keypad scanner with debounce and 16-bit key shift register
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      sync1;
  logic [3:0]      rs;
  logic [PW-1:0]   prescaler;
  logic [CW-1:0]   count;
  logic [1:0]      col_idx;
  logic [1:0]      cand_r;
  logic [1:0]      hit_r;
  logic [1:0]      next_idx;
  logic [3:0]      confirm_code;
  logic            tick;
  logic            any_low;
  logic            cand_low;

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b1000 >> idx;
    return ~onehot;
  endfunction

  assign tick         = (prescaler == PRE_LAST);
  assign any_low      = (rs != 4'b1111);
  assign cand_low     = ~rs[2'd3 - cand_r];
  assign next_idx     = col_idx + 2'd1;
  assign confirm_code = {cand_r, col_idx};

  // Lowest-numbered active row wins when several are low together.
  always_comb begin
    hit_r = 2'd3;
    if (!rs[3])      hit_r = 2'd0;
    else if (!rs[2]) hit_r = 2'd1;
    else if (!rs[1]) hit_r = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 4'b1111;
      rs        <= 4'b1111;
      prescaler <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b0111;
      state     <= SCAN;
      count     <= '0;
      cand_r    <= 2'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
      value     <= 16'h0000;
    end else begin
      sync1     <= row;
      rs        <= sync1;
      key_valid <= 1'b0;
      prescaler <= tick ? '0 : prescaler + PW'(1);

      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              cand_r <= hit_r;
              count  <= '0;
              state  <= DEBOUNCE;
            end else begin
              col_idx <= next_idx;
              col     <= col_decode(next_idx);
            end
          end
          DEBOUNCE: begin
            if (cand_low) begin
              if (count == CNT_LAST) begin
                key_valid <= 1'b1;
                key_code  <= confirm_code;
                value     <= {value[11:0], confirm_code};
                key_held  <= 1'b1;
                count     <= '0;
                state     <= HELD;
              end else begin
                count <= count + CW'(1);
              end
            end else begin
              col_idx <= next_idx;
              col     <= col_decode(next_idx);
              state   <= SCAN;
            end
          end
          HELD: begin
            // Any low row restarts the release count; extra keys are ignored.
            if (!any_low) begin
              if (count == CNT_LAST) begin
                key_held <= 1'b0;
                col_idx  <= next_idx;
                col      <= col_decode(next_idx);
                count    <= '0;
                state    <= SCAN;
              end else begin
                count <= count + CW'(1);
              end
            end else begin
              count <= '0;
            end
          end
          default: begin
            state <= SCAN;
            count <= '0;
          end
        endcase
      end

      if (clear) value <= 16'h0000;
    end
  end

endmodule
